// File: rtl/sym8b10b_pkg.sv
// Shared constants, LFSR helper and lane FSM state type for the 8b/10b BIST checker.
package sym8b10b_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;

    localparam int                LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;  // s[15]^s[13]^s[12]^s[10]

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCKED
    } lane_state_e;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sym8b10b_bist_lane.sv
// One-lane checker: regenerates comma + LFSR frame, tracks lock, counts bad symbols.
module sym8b10b_bist_lane
    import sym8b10b_pkg::*;
#(
    parameter int                ERR_CNT_W = 16,
    parameter int                K_PERIOD  = 16,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int                LOCK_GOOD = 8,
    parameter int                LOSE_BAD  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 din_val,
    input  logic [7:0]           din_dat,
    input  logic                 din_k,
    input  logic                 din_kerr,
    input  logic                 din_rderr,
    output logic                 lock,
    output logic                 lock_lost,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int POS_W  = (K_PERIOD > 2) ? $clog2(K_PERIOD) : 1;
    localparam int GOOD_W = $clog2(LOCK_GOOD + 1);
    localparam int BAD_W  = $clog2(LOSE_BAD + 1);

    lane_state_e          state_q, state_d;
    logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic [GOOD_W-1:0]    good_run_q, good_run_d;
    logic [BAD_W-1:0]     bad_run_q, bad_run_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 lock_q, lock_d;
    logic                 lock_lost_q, lock_lost_d;
    logic                 err_pulse_q, err_pulse_d;

    logic is_comma;
    logic exp_comma;
    logic sym_good;
    logic drop;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        is_comma  = din_k && (din_dat == K28_5) && !din_kerr;
        exp_comma = (pos_q == '0);
        sym_good  = !din_kerr && !din_rderr &&
                    (exp_comma ? (din_k && din_dat == K28_5)
                               : (!din_k && din_dat == lfsr_q[7:0]));
        drop        = 1'b0;
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        pos_d       = pos_q;
        good_run_d  = good_run_q;
        bad_run_d   = bad_run_q;
        err_cnt_d   = err_cnt_q;
        lock_d      = lock_q;
        lock_lost_d = lock_lost_q;
        err_pulse_d = 1'b0;

        if (din_val) begin
            // The expected stream advances on every valid symbol, good or bad.
            lfsr_d = exp_comma ? SEED : lfsr_step(lfsr_q);
            pos_d  = (pos_q == POS_W'(K_PERIOD - 1)) ? '0 : pos_q + 1'b1;

            case (state_q)
                HUNT: begin
                    if (is_comma) begin
                        lfsr_d     = SEED;
                        pos_d      = POS_W'(1);
                        good_run_d = GOOD_W'(1);
                        bad_run_d  = '0;
                        if (LOCK_GOOD <= 1) begin
                            state_d = LOCKED;
                            lock_d  = 1'b1;
                        end else begin
                            state_d = SYNC;
                        end
                    end
                end
                SYNC: begin
                    if (sym_good) begin
                        good_run_d = good_run_q + 1'b1;
                        if (good_run_d == GOOD_W'(LOCK_GOOD)) begin
                            state_d   = LOCKED;
                            lock_d    = 1'b1;
                            bad_run_d = '0;
                        end
                    end else begin
                        state_d    = HUNT;
                        good_run_d = '0;
                    end
                end
                LOCKED: begin
                    if (sym_good) begin
                        bad_run_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                        bad_run_d = bad_run_q + 1'b1;
                        if (bad_run_d == BAD_W'(LOSE_BAD)) begin
                            drop        = 1'b1;
                            state_d     = HUNT;
                            lock_d      = 1'b0;
                            lock_lost_d = 1'b1;
                            bad_run_d   = '0;
                            good_run_d  = '0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        // Clear beats a counted error, but a lock drop in the same cycle still sets lock_lost.
        if (clr) begin
            err_cnt_d   = '0;
            lock_lost_d = drop;
        end
    end

    // NOTE: state is updated only with non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            lfsr_q      <= SEED;
            pos_q       <= '0;
            good_run_q  <= '0;
            bad_run_q   <= '0;
            err_cnt_q   <= '0;
            lock_q      <= 1'b0;
            lock_lost_q <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            pos_q       <= pos_d;
            good_run_q  <= good_run_d;
            bad_run_q   <= bad_run_d;
            err_cnt_q   <= err_cnt_d;
            lock_q      <= lock_d;
            lock_lost_q <= lock_lost_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign lock      = lock_q;
    assign lock_lost = lock_lost_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: rtl/sym8b10b_bist_checker.sv
// Multi-lane BIST checker: one independent sym8b10b_bist_lane per lane, no deskew.
module sym8b10b_bist_checker
    import sym8b10b_pkg::*;
#(
    parameter int                LANES     = 4,
    parameter int                ERR_CNT_W = 16,
    parameter int                K_PERIOD  = 16,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int                LOCK_GOOD = 8,
    parameter int                LOSE_BAD  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic [LANES-1:0]           din_val,
    input  logic [8*LANES-1:0]         din_dat,
    input  logic [LANES-1:0]           din_k,
    input  logic [LANES-1:0]           din_kerr,
    input  logic [LANES-1:0]           din_rderr,
    output logic [LANES-1:0]           lock,
    output logic [LANES-1:0]           lock_lost,
    output logic [LANES-1:0]           err_pulse,
    output logic [ERR_CNT_W*LANES-1:0] err_cnt
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sym8b10b_bist_lane #(
            .ERR_CNT_W (ERR_CNT_W),
            .K_PERIOD  (K_PERIOD),
            .SEED      (SEED),
            .LOCK_GOOD (LOCK_GOOD),
            .LOSE_BAD  (LOSE_BAD)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clr),
            .din_val   (din_val[i]),
            .din_dat   (din_dat[8*i +: 8]),
            .din_k     (din_k[i]),
            .din_kerr  (din_kerr[i]),
            .din_rderr (din_rderr[i]),
            .lock      (lock[i]),
            .lock_lost (lock_lost[i]),
            .err_pulse (err_pulse[i]),
            .err_cnt   (err_cnt[ERR_CNT_W*i +: ERR_CNT_W])
        );
    end

endmodule

// File: tb/tb_sym8b10b_bist_checker.sv
// Directed bench: 4-lane default checker plus a 1-lane narrow-counter instance on lane 0's stream.
module tb_sym8b10b_bist_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [3:0]  din_val, din_k, din_kerr, din_rderr;
    logic [31:0] din_dat;
    logic [3:0]  lock, lock_lost, err_pulse;
    logic [63:0] err_cnt;
    logic        b_lock, b_lock_lost, b_err_pulse;
    logic [3:0]  b_err_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int tb_pos   = 0;

    always #5 clk = ~clk;

    sym8b10b_bist_checker #(.LANES(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .din_val(din_val), .din_dat(din_dat), .din_k(din_k),
        .din_kerr(din_kerr), .din_rderr(din_rderr),
        .lock(lock), .lock_lost(lock_lost), .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    sym8b10b_bist_checker #(.LANES(1), .ERR_CNT_W(4), .LOSE_BAD(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .din_val(din_val[0]), .din_dat(din_dat[7:0]), .din_k(din_k[0]),
        .din_kerr(din_kerr[0]), .din_rderr(din_rderr[0]),
        .lock(b_lock), .lock_lost(b_lock_lost), .err_pulse(b_err_pulse), .err_cnt(b_err_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference data byte for frame position p (1..15), stepping the LFSR from the seed.
    function automatic logic [7:0] exp_byte(input int p);
        logic [15:0] s;
        s = 16'hACE1;
        for (int j = 1; j < p; j++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        return s[7:0];
    endfunction

    // Apply one symbol slot to all lanes (correct symbol for tb_pos, optionally corrupted).
    task automatic drive(input logic [3:0] val, input logic [3:0] flip,
                         input logic [3:0] rderr, input logic clr_in);
        for (int l = 0; l < 4; l++) begin
            din_dat[8*l +: 8] = ((tb_pos == 0) ? 8'hBC : exp_byte(tb_pos)) ^ (flip[l] ? 8'h01 : 8'h00);
            din_k[l]          = (tb_pos == 0);
        end
        din_val   = val;
        din_kerr  = 4'b0000;
        din_rderr = rderr;
        clr       = clr_in;
        @(posedge clk);
        #1;
        if (val != '0) tb_pos = (tb_pos + 1) % 16;
        din_val = '0;
        clr     = 1'b0;
    endtask

    typedef struct {
        logic        flip;
        logic        exp_lock;
        logic        exp_pulse;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[48];

    initial begin
        // Three frames on lane 0: lock after the 8th good symbol, one flipped byte at frame 2 pos 5.
        for (int i = 0; i < 48; i++) begin
            vecs[i].flip      = (i == 37);
            vecs[i].exp_lock  = (i >= 7);
            vecs[i].exp_pulse = (i == 37);
            vecs[i].exp_cnt   = (i >= 37) ? 16'd1 : 16'd0;
        end

        rst_n = 1'b0; clr = 1'b0;
        din_val = '0; din_k = '0; din_kerr = '0; din_rderr = '0; din_dat = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_lock",      64'(lock),      64'h0);
        check("rst_lock_lost", 64'(lock_lost), 64'h0);
        check("rst_err_pulse", 64'(err_pulse), 64'h0);
        check("rst_err_cnt",   err_cnt,        64'h0);
        check("rst_b_lock",    64'(b_lock),    64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Acquisition and single data error, table driven.
        for (int i = 0; i < 48; i++) begin
            drive(4'hF, {3'b000, vecs[i].flip}, 4'h0, 1'b0);
            check($sformatf("v%0d_lock0", i),  64'(lock[0]),        64'(vecs[i].exp_lock));
            check($sformatf("v%0d_lock1", i),  64'(lock[1]),        64'(vecs[i].exp_lock));
            check($sformatf("v%0d_pulse0", i), 64'(err_pulse[0]),   64'(vecs[i].exp_pulse));
            check($sformatf("v%0d_cnt0", i),   64'(err_cnt[15:0]),  64'(vecs[i].exp_cnt));
            check($sformatf("v%0d_b_lock", i), 64'(b_lock),         64'(vecs[i].exp_lock));
            check($sformatf("v%0d_b_cnt", i),  64'(b_err_cnt),      64'(vecs[i].exp_cnt[3:0]));
        end

        // Lane 1: four consecutive disparity errors drop lock.
        for (int k = 1; k <= 4; k++) begin
            drive(4'hF, 4'h0, 4'b0010, 1'b0);
            check($sformatf("rd%0d_pulse1", k), 64'(err_pulse[1]),  64'h1);
            check($sformatf("rd%0d_cnt1", k),   64'(err_cnt[31:16]), 64'(k));
            check($sformatf("rd%0d_lock1", k),  64'(lock[1]),       64'(k < 4));
            check($sformatf("rd%0d_lost1", k),  64'(lock_lost[1]),  64'(k == 4));
        end
        check("rd_lock2",  64'(lock[2]),         64'h1);
        check("rd_cnt2",   64'(err_cnt[47:32]),  64'h0);
        check("rd_lost2",  64'(lock_lost[2]),    64'h0);
        check("rd_cnt0",   64'(err_cnt[15:0]),   64'h1);
        check("rd_lock0",  64'(lock[0]),         64'h1);

        // Lane 1 in SYNC: bad symbol at good_run=5 returns to HUNT, then a full reacquire.
        while (tb_pos != 0) begin
            drive(4'hF, 4'h0, 4'h0, 1'b0);
            check("hunt_lock1", 64'(lock[1]), 64'h0);
        end
        for (int p = 0; p < 5; p++) begin
            drive(4'hF, 4'h0, 4'h0, 1'b0);
            check($sformatf("sync%0d_lock1", p), 64'(lock[1]), 64'h0);
        end
        drive(4'hF, 4'b0010, 4'h0, 1'b0);
        check("syncbad_lock1",  64'(lock[1]),         64'h0);
        check("syncbad_pulse1", 64'(err_pulse[1]),    64'h0);
        check("syncbad_cnt1",   64'(err_cnt[31:16]),  64'h4);
        while (tb_pos != 0) begin
            drive(4'hF, 4'h0, 4'h0, 1'b0);
            check("rehunt_lock1", 64'(lock[1]), 64'h0);
        end
        for (int p = 0; p < 8; p++) begin
            drive(4'hF, 4'h0, 4'h0, 1'b0);
            check($sformatf("reacq%0d_lock1", p), 64'(lock[1]), 64'(p == 7));
        end
        check("reacq_cnt1", 64'(err_cnt[31:16]), 64'h4);

        // Narrow counter saturation on the 1-lane instance (LOSE_BAD=32 keeps it locked).
        for (int n = 1; n <= 20; n++) begin
            drive(4'hF, 4'b0001, 4'h0, 1'b0);
            check($sformatf("sat%0d_b_cnt", n),   64'(b_err_cnt),   64'((n + 1 > 15) ? 15 : n + 1));
            check($sformatf("sat%0d_b_pulse", n), 64'(b_err_pulse), 64'h1);
            check($sformatf("sat%0d_b_lock", n),  64'(b_lock),      64'h1);
        end
        check("sat_cnt0",  64'(err_cnt[15:0]), 64'h5);
        check("sat_lock0", 64'(lock[0]),       64'h0);
        check("sat_lost0", 64'(lock_lost[0]),  64'h1);

        // clr together with a counted error: count cleared, pulse still fires.
        drive(4'hF, 4'b0001, 4'h0, 1'b1);
        check("clr_b_cnt",   64'(b_err_cnt),   64'h0);
        check("clr_b_pulse", 64'(b_err_pulse), 64'h1);
        check("clr_err_cnt", err_cnt,          64'h0);
        check("clr_lost",    64'(lock_lost),   64'h0);
        drive(4'hF, 4'h0, 4'h0, 1'b0);
        check("postclr_b_cnt", 64'(b_err_cnt), 64'h0);

        // clr in the same cycle lane 2 drops lock: lock_lost set wins.
        for (int n = 1; n <= 3; n++) begin
            drive(4'hF, 4'b0100, 4'h0, 1'b0);
            check($sformatf("sw%0d_lock2", n), 64'(lock[2]), 64'h1);
        end
        drive(4'hF, 4'b0100, 4'h0, 1'b1);
        check("sw_lock2",  64'(lock[2]),        64'h0);
        check("sw_lost2",  64'(lock_lost[2]),   64'h1);
        check("sw_cnt2",   64'(err_cnt[47:32]), 64'h0);
        check("sw_pulse2", 64'(err_pulse[2]),   64'h1);
        check("sw_lost1",  64'(lock_lost[1]),   64'h0);

        // Random valid gaps on a clean stream never produce errors.
        for (int c = 0; c < 200; c++) begin
            drive(($urandom_range(0, 1) != 0) ? 4'hF : 4'h0, 4'h0, 4'h0, 1'b0);
            check("gap_pulse",   64'(err_pulse),   64'h0);
            check("gap_b_pulse", 64'(b_err_pulse), 64'h0);
        end
        for (int c = 0; c < 32; c++) drive(4'hF, 4'h0, 4'h0, 1'b0);
        check("gap_lock",    64'(lock),      64'hF);
        check("gap_err_cnt", err_cnt,        64'h0);
        check("gap_b_cnt",   64'(b_err_cnt), 64'h0);
        check("gap_lost",    64'(lock_lost), 64'h4);

        // Async reset mid-frame, right after a counted error on lane 3.
        drive(4'hF, 4'b1000, 4'h0, 1'b0);
        check("pre_rst_cnt3", 64'(err_cnt[63:48]), 64'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_lock",      64'(lock),        64'h0);
        check("arst_lock_lost", 64'(lock_lost),   64'h0);
        check("arst_err_pulse", 64'(err_pulse),   64'h0);
        check("arst_err_cnt",   err_cnt,          64'h0);
        check("arst_b_lock",    64'(b_lock),      64'h0);
        check("arst_b_cnt",     64'(b_err_cnt),   64'h0);
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) drive(4'hF, 4'h0, 4'h0, 1'b0);
        check("reacq_lock",    64'(lock),      64'hF);
        check("reacq_b_lock",  64'(b_lock),    64'h1);
        check("reacq_lost",    64'(lock_lost), 64'h0);
        check("reacq_err_cnt", err_cnt,        64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
